// File: rtl/wb_frame_ram.sv
// Byte-wide Wishbone B4 frame scratch RAM with classic and incrementing-burst support.
// Optional out-of-range error response when WB_FRAME_RAM_ERR_EN is defined (adds err_o).
`timescale 1ns/1ps

module wb_frame_ram #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       DATA_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = 16'h0000,
  parameter int                       MEM_DEPTH     = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [ADDRESS_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  input  logic                     we_i,
  input  logic                     sel_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  input  logic [2:0]               cti_i,
  output logic                     ack_o
`ifdef WB_FRAME_RAM_ERR_EN
  ,
  output logic                     err_o
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int XW = ADDRESS_WIDTH + 2;
  localparam logic [XW-1:0] LP_DEPTH = XW'(MEM_DEPTH);

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   w_addr_next;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [XW-1:0]   w_off;
  logic            w_below;
  logic            w_in_range;
  logic            w_req;
  logic            w_hit;
  logic [AW-1:0]   w_local;
  logic            w_ack;
  logic            w_wr_en;

  // Offset is computed two bits wider so addresses below the base show up as a borrow
  assign w_off      = {2'b00, adr_i} - {2'b00, BASE_ADDRESS};
  assign w_below    = w_off[XW-1];
  assign w_in_range = !w_below && (w_off < LP_DEPTH);
  assign w_req      = cyc_i & stb_i;
  assign w_hit      = w_req & w_in_range;
  assign w_local    = w_off[AW-1:0];

  assign w_ack   = (r_state == SINGLE) || ((r_state == BURST) && w_req);
  assign w_wr_en = w_ack & we_i & sel_i;

  assign ack_o = w_ack;
  assign dat_o = w_ack ? r_rdata : '0;

  // w_addr_next is the address of the beat acked in the following cycle; it also drives
  // the RAM read port so registered read data lines up with ack_o at one beat per clock.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_addr_next  = w_local;
          w_state_next = (cti_i == CTI_INCR) ? BURST : SINGLE;
        end
      end
      SINGLE: begin
        w_state_next = IDLE;
      end
      BURST: begin
        if (!cyc_i) begin
          w_state_next = IDLE;
        end else if (stb_i) begin
          w_addr_next = r_addr + 1'b1;
          if (cti_i == CTI_END) begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
    end
  end

  // Writes land at the end of an acked beat; reset clears the state so no write can slip through
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_addr] <= dat_i;
    end
    r_rdata <= r_mem[w_addr_next];
  end

`ifdef WB_FRAME_RAM_ERR_EN
  localparam logic [XW-1:0] LP_WINDOW = XW'(2 * MEM_DEPTH);

  logic w_in_window;
  logic r_err;

  assign w_in_window = !w_below && (w_off < LP_WINDOW);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && !r_err && w_req && !w_in_range && w_in_window;
    end
  end

  assign err_o = r_err;
`endif

endmodule
